bitonic_8_be_arbiter: RTL and testbench

//   Shares one pipelined 8-input bitonic backend between NREQ requesters. Round-robin arbiter

---
 rtl/bitonic_8_be_arbiter.sv | 145 ++++++++++++++
 tb/tb_bitonic_8_be_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_8_be_arbiter.sv
// Round-robin front end sharing one pipelined 8-input bitonic backend between NREQ requesters.
// Optional sticky protocol checker enabled by defining BITONIC_BE_ARB_CHECK_EN.
module bitonic_8_be_arbiter #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 8,
  parameter int NREQ       = 4,
  parameter int BE_LATENCY = 3,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [NREQ-1:0]                      req_valid_i,
  output logic [NREQ-1:0]                      req_ready_o,
  input  logic [NREQ*DATALENGTH*DATAWIDTH-1:0] req_data_i,
  output logic                                 be_valid_o,
  output logic [DATALENGTH*DATAWIDTH-1:0]      be_x_o,
  input  logic                                 be_valid_i,
  input  logic [DATALENGTH*DATAWIDTH-1:0]      be_y_i,
  output logic [NREQ-1:0]                      rsp_valid_o,
  input  logic [NREQ-1:0]                      rsp_ready_i,
  output logic [NREQ*DATALENGTH*DATAWIDTH-1:0] rsp_data_o,
  output logic                                 err_o
);

  localparam int VW  = DATALENGTH * DATAWIDTH;
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(OUT_DEPTH + 1);

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return IDW'(s % NREQ);
  endfunction

  logic [IDW-1:0] rr_ptr, win_id, cand, be_id;
  logic           win_vld;
  logic [CW-1:0]  credit [NREQ];

  logic [BE_LATENCY-1:0] tag_vld;
  logic [IDW-1:0]        tag_id [BE_LATENCY];

  logic [PW-1:0]  wr_ptr [NREQ];
  logic [PW-1:0]  rd_ptr [NREQ];
  logic [CW-1:0]  count  [NREQ];
  logic [VW-1:0]  mem    [NREQ][OUT_DEPTH];
  logic [NREQ-1:0] push, pop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    win_vld     = 1'b0;
    win_id      = '0;
    cand        = '0;
    req_ready_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!win_vld && req_valid_i[cand] && credit[cand] != '0) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
    if (win_vld) req_ready_o[win_id] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr     <= '0;
      be_valid_o <= 1'b0;
      be_x_o     <= '0;
      be_id      <= '0;
      tag_vld    <= '0;
      for (int s = 0; s < BE_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      be_valid_o <= win_vld;
      if (win_vld) begin
        be_x_o <= req_data_i[win_id*VW +: VW];
        be_id  <= win_id;
        rr_ptr <= wrap_add(win_id, 1);
      end
      // The tag pipe trails be_valid_o so its last stage coincides with be_valid_i.
      tag_vld[0] <= be_valid_o;
      tag_id[0]  <= be_id;
      for (int s = 1; s < BE_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NREQ; i++) begin
      push[i] = tag_vld[BE_LATENCY-1] && (tag_id[BE_LATENCY-1] == IDW'(i));
      pop[i]  = rsp_valid_o[i] && rsp_ready_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        credit[i] <= CW'(OUT_DEPTH);
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i]  <= count[i] + CW'(push[i]) - CW'(pop[i]);
        credit[i] <= credit[i] - CW'(req_ready_o[i]) + CW'(pop[i]);
      end
    end
  end

  // NOTE: FIFO storage is not reset; the counts alone decide what is visible.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= be_y_i;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_o[i] = (count[i] != '0);
      if (count[i] != '0) rsp_data_o[i*VW +: VW] = mem[i][rd_ptr[i]];
    end
  end

`ifdef BITONIC_BE_ARB_CHECK_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_o <= 1'b0;
    else if (be_valid_i != tag_vld[BE_LATENCY-1]) err_o <= 1'b1;
  end
`else
  logic unused_be_valid;
  assign unused_be_valid = be_valid_i;
  assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_bitonic_8_be_arbiter.sv
// Self-checking bench: sorting backend model plus a queue-based reference of grants,
// credits, FIFO contents and result latency.
module tb_bitonic_8_be_arbiter;

  localparam int DW = 8, DL = 8, NREQ = 4, LAT = 3, DEPTH = 4, VW = DW * DL;

  logic                 clk_i = 1'b0;
  logic                 rstn_i = 1'b0;
  logic [NREQ-1:0]      req_valid_i = '0;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*VW-1:0]   req_data_i = '0;
  logic                 be_valid_o;
  logic [VW-1:0]        be_x_o;
  logic                 be_valid_i;
  logic [VW-1:0]        be_y_i;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i = '0;
  logic [NREQ*VW-1:0]   rsp_data_o;
  logic                 err_o;

  bitonic_8_be_arbiter #(
    .DATAWIDTH(DW), .DATALENGTH(DL), .NREQ(NREQ), .BE_LATENCY(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .be_valid_o(be_valid_o), .be_x_o(be_x_o), .be_valid_i(be_valid_i), .be_y_i(be_y_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
    logic [DW-1:0] e [DL];
    logic [DW-1:0] t;
    logic [VW-1:0] r;
    for (int i = 0; i < DL; i++) e[i] = v[i*DW +: DW];
    for (int i = 0; i < DL - 1; i++)
      for (int j = 0; j < DL - 1 - i; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    for (int i = 0; i < DL; i++) r[i*DW +: DW] = e[i];
    return r;
  endfunction

  // Backend: fixed-latency ascending sorter, never reset, plus an injection hook.
  logic [LAT-1:0] bp_v = '0;
  logic [VW-1:0]  bp_d [LAT];
  logic           inj = 1'b0;
  initial for (int s = 0; s < LAT; s++) bp_d[s] = '0;
  always @(posedge clk_i) begin
    bp_v[0] <= be_valid_o;
    bp_d[0] <= sort_vec(be_x_o);
    for (int s = 1; s < LAT; s++) begin
      bp_v[s] <= bp_v[s-1];
      bp_d[s] <= bp_d[s-1];
    end
  end
  assign be_valid_i = bp_v[LAT-1] | inj;
  assign be_y_i     = bp_d[LAT-1];

  // Reference: results become visible LAT+2 cycles after accept; credit = DEPTH - outstanding.
  typedef struct { int id; logic [VW-1:0] y; int cnt; } fl_t;
  fl_t           fl_q[$];
  logic [VW-1:0] vis_q [NREQ][$];
  int            rr = 0;
  logic          exp_be_v = 1'b0;
  logic [VW-1:0] exp_be_x = '0;
  logic          exp_err = 1'b0;
  int            dut_acc [NREQ];
  int            checks = 0, failures = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int credit_of(input int i);
    int c;
    c = DEPTH - vis_q[i].size();
    foreach (fl_q[k]) if (fl_q[k].id == i) c--;
    return c;
  endfunction

  task automatic clear_model();
    fl_q.delete();
    for (int i = 0; i < NREQ; i++) vis_q[i].delete();
    rr = 0; exp_be_v = 1'b0; exp_be_x = '0; exp_err = 1'b0;
  endtask

  task automatic step();
    logic [NREQ-1:0] g;
    logic            tag_v;
    int              w, idx;
    @(negedge clk_i);
    if (!rstn_i) clear_model();
    g = '0; w = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (rr + k) % NREQ;
      if (w < 0 && req_valid_i[idx] && credit_of(idx) > 0) w = idx;
    end
    if (w >= 0) g[w] = 1'b1;
    check("req_ready", VW'(req_ready_o), VW'(g));
    check("be_valid", VW'(be_valid_o), VW'(exp_be_v));
    check("be_x", be_x_o, exp_be_x);
    check("err", VW'(err_o), VW'(exp_err));
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("rsp_valid%0d", i), VW'(rsp_valid_o[i]), VW'(vis_q[i].size() != 0));
      check($sformatf("rsp_data%0d", i), rsp_data_o[i*VW +: VW],
            (vis_q[i].size() != 0) ? vis_q[i][0] : '0);
    end
    tag_v = 1'b0;
    foreach (fl_q[k]) if (fl_q[k].cnt == 1) tag_v = 1'b1;
    if (rstn_i) begin
`ifdef BITONIC_BE_ARB_CHECK_EN
      if (be_valid_i !== tag_v) exp_err = 1'b1;
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) dut_acc[i]++;
        if (vis_q[i].size() != 0 && rsp_ready_i[i]) void'(vis_q[i].pop_front());
      end
      foreach (fl_q[k]) fl_q[k].cnt = fl_q[k].cnt - 1;
      while (fl_q.size() > 0 && fl_q[0].cnt == 0) begin
        vis_q[fl_q[0].id].push_back(fl_q[0].y);
        void'(fl_q.pop_front());
      end
      exp_be_v = (w >= 0);
      if (w >= 0) begin
        fl_q.push_back('{id: w, y: sort_vec(req_data_i[w*VW +: VW]), cnt: LAT + 1});
        exp_be_x = req_data_i[w*VW +: VW];
        rr = (w + 1) % NREQ;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NREQ * VW / 32; i++) req_data_i[i*32 +: 32] = $urandom;
  endtask

  task automatic run(input int n, input logic rand_data);
    for (int c = 0; c < n; c++) begin
      if (rand_data) randomize_data();
      step();
    end
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    req_valid_i = '0;
    run(2, 1'b0);
    rstn_i = 1'b1;
  endtask

  int base1;

  initial begin
    for (int i = 0; i < NREQ; i++) dut_acc[i] = 0;
    do_reset();

    // Single vector from requester 0.
    rsp_ready_i = '1;
    req_data_i  = '0;
    for (int e = 0; e < DL; e++) req_data_i[e*DW +: DW] = DW'(e);
    req_valid_i = 4'b0001;
    step();
    req_valid_i = '0;
    run(8, 1'b0);

    // All requesters streaming with every FIFO draining.
    req_valid_i = '1;
    run(20, 1'b1);
    req_valid_i = '0;
    run(8, 1'b0);

    // Requester 1 blocked downstream: credits cap it at DEPTH accepts.
    rsp_ready_i = 4'b1101;
    req_valid_i = '1;
    base1 = dut_acc[1];
    run(20, 1'b1);
    check("acc1_capped", VW'(dut_acc[1] - base1), VW'(DEPTH));
    base1 = dut_acc[1];
    rsp_ready_i = 4'b1111;
    step();
    rsp_ready_i = 4'b1101;
    run(12, 1'b1);
    check("acc1_after_pop", VW'(dut_acc[1] - base1), VW'(1));
    req_valid_i = '0;
    rsp_ready_i = '1;
    run(8, 1'b0);

    // Random valid/ready traffic, exercising simultaneous accept and pop at low credit.
    for (int c = 0; c < 100; c++) begin
      req_valid_i = NREQ'($urandom);
      rsp_ready_i = NREQ'($urandom);
      rsp_ready_i[2] = ($urandom_range(0, 3) == 0);
      randomize_data();
      step();
    end
    req_valid_i = '0;
    rsp_ready_i = '1;
    run(10, 1'b0);

    // Reset with vectors in flight; stale backend results must be dropped.
    req_valid_i = '1;
    run(5, 1'b1);
    do_reset();
    run(8, 1'b0);

    // Stray backend valid with no issue.
    do_reset();
    inj = 1'b1;
    step();
    inj = 1'b0;
    run(4, 1'b0);

    // Credits are back to full: four vectors per requester are accepted without pops.
    rsp_ready_i = '0;
    req_valid_i = '1;
    run(24, 1'b1);
    req_valid_i = '0;
    rsp_ready_i = '1;
    run(10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
